// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and helpers for the multiport register file.
// Contents:
//   DATA_W_DEF / ADDR_W_DEF  default register width and address width
//   slice_field()            extracts field idx of a packed multi-port vector
package reg_file_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;

  // Widest packed port vector and widest single field the slicer handles
  // (4 ports x 64 bits). Callers zero-extend into SLICE_VEC_W and truncate
  // the result back to their own field width.
  localparam int SLICE_VEC_W   = 256;
  localparam int SLICE_FIELD_W = 64;

  function automatic logic [SLICE_FIELD_W-1:0] slice_field(
    input logic [SLICE_VEC_W-1:0] vec,
    input int unsigned            idx,
    input int unsigned            width
  );
    logic [SLICE_VEC_W-1:0]   shifted;
    logic [SLICE_FIELD_W-1:0] mask;
    shifted = vec >> (idx * width);
    mask    = (SLICE_FIELD_W'(1) << width) - SLICE_FIELD_W'(1);
    return SLICE_FIELD_W'(shifted) & mask;
  endfunction

endpackage

// File: rtl/reg_file_multiport_if.sv
// reg_file_multiport_if: bundle of read, write and lock signals of the
// multiport register file.
//   rd_addr    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_pending per-port pending flag of the addressed register
//   wr_en / wr_addr / wr_data     writeback port
//   lock_en / lock_addr           destination issued by decode
// Modports: master (pipeline side), slave (register file).
interface reg_file_multiport_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W_DEF,
  parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     lock_en;
  logic [ADDR_W-1:0]        lock_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    input  rd_data, rd_pending
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    output rd_data, rd_pending
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one pending bit per register, set when decode issues
// an instruction writing it, cleared when writeback retires it.
//   clk, rst        clock, async active-high reset (clears all bits)
//   lock_en/addr    set pending[lock_addr]
//   clr_en/addr     clear pending[clr_addr]; a lock to the same address wins
//   rd_addr         packed NUM_RD read addresses
//   pending_raw     stored pending bit for each read port
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        pending_raw
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]       pending;
  logic [DEPTH-1:0]       pending_nxt;
  logic [SLICE_VEC_W-1:0] rd_addr_pad;

  // Set is applied after clear so a new producer issued in the same cycle
  // the old one retires keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (clr_en)  pending_nxt[clr_addr]  = 1'b0;
    if (lock_en) pending_nxt[lock_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign rd_addr_pad = SLICE_VEC_W'(rd_addr);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign pending_raw[k] = pending[ADDR_W'(slice_field(rd_addr_pad, k, ADDR_W))];
  end

endmodule

// File: rtl/reg_file_multiport.sv
// reg_file_multiport: DEPTH x DATA_W register file with NUM_RD combinational
// read ports, one synchronous write port and a per-register pending
// scoreboard for read-after-write hazard detection.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears data and pending bits
//   bus   reg_file_multiport_if.slave (reads, writeback, lock)
// Build option: REG_FILE_BYPASS_EN enables write-first forwarding of wr_data
// onto matching read ports, and masks their pending flag unless a lock to the
// same address is issued in that cycle.
module reg_file_multiport
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_multiport_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD-1:0]        pending_raw;
  logic [SLICE_VEC_W-1:0]   rd_addr_pad;
  logic [NUM_RD*DATA_W-1:0] rd_data_int;
  logic [NUM_RD-1:0]        rd_pending_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .lock_en     (bus.lock_en),
    .lock_addr   (bus.lock_addr),
    .clr_en      (bus.wr_en),
    .clr_addr    (bus.wr_addr),
    .rd_addr     (bus.rd_addr),
    .pending_raw (pending_raw)
  );

  assign rd_addr_pad = SLICE_VEC_W'(bus.rd_addr);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = ADDR_W'(slice_field(rd_addr_pad, k, ADDR_W));
`ifdef REG_FILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay zero.
    logic hit;
    assign hit = !rst && bus.wr_en && (bus.wr_addr == addr);
    assign rd_data_int[k*DATA_W +: DATA_W] = hit ? bus.wr_data : mem[addr];
    assign rd_pending_int[k] = hit ? (bus.lock_en && (bus.lock_addr == addr))
                                   : pending_raw[k];
`else
    assign rd_data_int[k*DATA_W +: DATA_W] = mem[addr];
    assign rd_pending_int[k] = pending_raw[k];
`endif
  end

  assign bus.rd_data    = rd_data_int;
  assign bus.rd_pending = rd_pending_int;

endmodule

// File: tb/tb_reg_file_multiport.sv
module tb_reg_file_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_multiport_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus ();
  reg_file_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus_w ();

  reg_file_multiport #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  reg_file_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) dut_w (
    .clk (clk), .rst (rst), .bus (bus_w)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] got;

  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.lock_en   = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.lock_addr = '0;
    bus_w.wr_en     = 1'b0;
    bus_w.lock_en   = 1'b0;
    bus_w.wr_addr   = '0;
    bus_w.wr_data   = '0;
    bus_w.lock_addr = '0;
  endtask

  task automatic test_reset();
    // Still in reset from time zero: reads and pending must be zero.
    bus.rd_addr = {4'd3, 4'd3};
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_hold_data got %h want %h", got, exp); end
    @(negedge clk); rst = 1'b0;

    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hBEEF;
    bus.lock_en = 1'b1; bus.lock_addr = 4'd3;
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'h0000_BEEF);
    exp_q.push_back(32'h3);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_pre_data got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_pre_pending got %h want %h", got, exp); end

    // Mid-cycle reset: must clear without a clock edge.
    #2; rst = 1'b1; #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_async_data0 got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[31:16]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_async_data1 got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_async_pending got %h want %h", got, exp); end

    // Writes and locks presented across an edge while in reset are ignored.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h7777;
    bus.lock_en = 1'b1; bus.lock_addr = 4'd3;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_no_bypass got %h want %h", got, exp); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk); rst = 1'b0; #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_write_ignored got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_lock_ignored got %h want %h", got, exp); end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'h1234;
    bus.rd_addr = {4'd5, 4'd5};
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL wr_rd_port0 got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[31:16]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL wr_rd_port1 got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL wr_unlocked_pending got %h want %h", got, exp); end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h1111;
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'hA5A5;
    bus.rd_addr = {4'd5, 4'd7};
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_q.push_back(32'hA5A5);
`else
    exp_q.push_back(32'h1111);
`endif
    exp_q.push_back(32'h1234);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_before_edge got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[31:16]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_other_port got %h want %h", got, exp); end
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'hA5A5);
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bypass_after_edge got %h want %h", got, exp); end
  endtask

  task automatic test_scoreboard();
    @(posedge clk); #1;
    bus.lock_en = 1'b1; bus.lock_addr = 4'd2;
    bus.rd_addr = {4'd5, 4'd2};
    @(posedge clk); #1;   // edge N
    idle_inputs();
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sb_lock_set got %h want %h", got, exp); end
    // Second lock on an already pending register keeps it pending.
    bus.lock_en = 1'b1; bus.lock_addr = 4'd2;
    @(posedge clk); #1;   // edge N+1
    idle_inputs();
    @(posedge clk); #1;   // edge N+2
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sb_relock_hold got %h want %h", got, exp); end
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h2222;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_q.push_back(32'h0);
`else
    exp_q.push_back(32'h1);
`endif
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sb_clear_before_edge got %h want %h", got, exp); end
    @(posedge clk); #1;   // edge N+3
    idle_inputs();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h2222);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sb_cleared got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sb_clear_data got %h want %h", got, exp); end
  endtask

  task automatic test_simultaneous();
    // Make r4 and r9 pending.
    @(posedge clk); #1;
    bus.lock_en = 1'b1; bus.lock_addr = 4'd4;
    @(posedge clk); #1;
    bus.lock_en = 1'b1; bus.lock_addr = 4'd9;
    @(posedge clk); #1;
    // Same address: lock wins, data still updates.
    bus.lock_en = 1'b1; bus.lock_addr = 4'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'h4444;
    bus.rd_addr = {4'd9, 4'd4};
    #1;
    exp_q.push_back(32'h3);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_same_before_edge got %h want %h", got, exp); end
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h4444);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_same_pending got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[15:0]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_same_data got %h want %h", got, exp); end
    // Retire r4 so the next lock is observable.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'h4445;
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'h2);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_r4_retired got %h want %h", got, exp); end
    // Different addresses: lock r4, retire r9.
    bus.lock_en = 1'b1; bus.lock_addr = 4'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h9999;
    @(posedge clk); #1;
    idle_inputs();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h9999);
    exp = exp_q.pop_front(); got = 32'(bus.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_diff_pending got %h want %h", got, exp); end
    exp = exp_q.pop_front(); got = 32'(bus.rd_data[31:16]); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sim_diff_data got %h want %h", got, exp); end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      bus_w.wr_en = 1'b1; bus_w.wr_addr = 5'(i);
      bus_w.wr_data = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a0, a1, a2;
      a0 = 5'(i); a1 = 5'(i + 1); a2 = 5'(i + 7);
      bus_w.rd_addr = {a2, a1, a0};
      exp_q.push_back((32'(a0) * 32'h0101_0101) ^ 32'h5A5A_0000);
      exp_q.push_back((32'(a1) * 32'h0101_0101) ^ 32'h5A5A_0000);
      exp_q.push_back((32'(a2) * 32'h0101_0101) ^ 32'h5A5A_0000);
      #1;
      exp = exp_q.pop_front(); got = bus_w.rd_data[31:0]; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sweep_p0 addr %0d got %h want %h", a0, got, exp); end
      exp = exp_q.pop_front(); got = bus_w.rd_data[63:32]; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sweep_p1 addr %0d got %h want %h", a1, got, exp); end
      exp = exp_q.pop_front(); got = bus_w.rd_data[95:64]; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sweep_p2 addr %0d got %h want %h", a2, got, exp); end
    end
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); got = 32'(bus_w.rd_pending); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sweep_pending got %h want %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.rd_addr   = '0;
    bus_w.rd_addr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_sweep();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_multiport.md
Name: reg_file_multiport

Overview:
- Clocked, parametrised successor to the 16x16 combinational register file. Feeds the CPU decode stage and takes writeback from the final pipeline stage.
- Provides NUM_RD independent read ports, one synchronous write port and optional write-to-read bypass.
- Adds a per-register pending scoreboard so decode can detect read-after-write hazards against in-flight instructions.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
- rd_pending  out  NUM_RD  1 = the register addressed by port k has a pending write.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- lock_en  in  1  mark lock_addr pending (instruction issued with this destination).
- lock_addr  in  ADDR_W  destination to mark.

Behaviour:
- Storage: DEPTH x DATA_W registers, written only on the rising clk edge when wr_en=1.
- Async reset: rst=1 clears every register to 0 and every pending bit to 0 immediately, independent of clk.
- While rst=1: rd_data reads all zeros; rd_pending is all zeros; writes and locks are ignored.
- Reads: rd_data[k] = reg[rd_addr[k]] combinationally. Any number of ports may read the same address.
- Write latency: data written at edge N is visible on reads from edge N onward (after the edge).
- Scoreboard, per register, at each clk edge:
  - lock_en=1 sets pending[lock_addr].
  - wr_en=1 clears pending[wr_addr].
  - Same address, both asserted in one cycle: lock wins and the bit stays set (a new producer was issued as the old one retired).
  - Different addresses: both actions apply.
- rd_pending[k] = pending[rd_addr[k]], with the bypass adjustment when BYPASS_EN is defined (see Optional Feature).
- Rejected locks: lock_en on an already-pending register leaves it pending; no counting, one producer per register.
- Writes without a lock: wr_en on a non-pending register is legal; the data is written and pending stays 0.
- Address range: all addresses are in range by construction (width = ADDR_W); no wrap or error logic.
- Register 0 is an ordinary register.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - If wr_en=1 and wr_addr == rd_addr[k] in the same cycle, rd_data[k] = wr_data (write-first forwarding), combinationally.
  - rd_pending[k] reads 0 in that case unless lock_en targets the same address.
- Undefined:
  - Reads return the stored value (old data) until the edge.
  - rd_pending[k] reflects the stored pending bit only.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W and ADDR_W constants;
  - a function to slice the packed port vectors.
- Sub-module reg_file_scoreboard:
  - holds the DEPTH-bit pending vector, lock/clear logic and async reset;
  - takes NUM_RD read addresses and returns raw pending bits.
- The top module holds storage, read muxes and the bypass.

Test Plan:
- Reset: write 0xBEEF to r3, pulse rst mid-cycle -> rd_data for r3 is 0x0000 immediately, before the next edge; all rd_pending = 0.
- Write/read: wr_en, r5 <- 0x1234 at edge N; rd_addr0=5 -> 0x1234 after edge N; rd_addr1=5 simultaneously -> 0x1234.
- Bypass:
  - Same cycle, wr r7 <- 0xA5A5 and rd_addr0=7.
  - With REG_FILE_BYPASS_EN -> rd_data0 = 0xA5A5 before the edge.
  - Without the macro -> old value before the edge, 0xA5A5 after it.
- Scoreboard: lock r2 at edge N -> rd_pending0 = 1 for rd_addr0=2; wr r2 at edge N+3 -> rd_pending0 = 0 after N+3.
- Simultaneous events:
  - Same address: lock r4 and wr r4 in the same cycle, r4 pending beforehand -> pending stays 1 and data is updated.
  - Different addresses: lock r4 and wr r9 in the same cycle -> r4 pending, r9 clear.
- Parameter sweep: DATA_W=32, ADDR_W=5, NUM_RD=3 -> write all 32 registers with unique values and read back on all 3 ports without mismatch.
